uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1024: idle cycles allowed inside a granted packet before the grant is revoked.
REQ-002 Parameter INSERT_ID, default 1'b1: when 1, prefix every packet with an ID byte.
REQ-003 Parameter ID_BASE, default 8'hA0: the ID byte is ID_BASE + requester index.
REQ-004 clk_50m  input  1  the only clock; all logic rises on it.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  3  per requester i (0=SD, 1=SDRAM, 2=status): a byte is offered.
REQ-007 req_data  input  24  byte for requester i in bits [8i+7:8i].
REQ-008 req_last  input  3  per requester: the offered byte ends the packet.
REQ-009 req_ready  output  3  per requester: the offered byte is accepted this cycle.
REQ-010 fifo_full  input  1  UART TX FIFO full; asserted with at least one free entry of margin.
REQ-011 fifo_tx_req  output  1  one-cycle FIFO write strobe.
REQ-012 fifo_tx_data  output  8  FIFO write byte.
REQ-013 grant  output  2  index of the owning requester; 2'd3 = none.
REQ-014 drop_cnt  output  8  count of packets aborted by timeout; saturates at 8'hFF.

Function
REQ-015 The state machine SHALL have states IDLE, HDR and DATA.
REQ-016 IDLE: when any req_valid is 1, grant the first requester with req_valid=1, searching round-robin from (last_grant+1) mod 3.
  - On a grant, go to HDR if INSERT_ID=1, else to DATA.
  - last_grant resets to 2, so requester 0 has priority first.
REQ-017 HDR: when fifo_full=0, write ID_BASE+grant (fifo_tx_req=1 the next cycle), then go to DATA.
  - While fifo_full=1, remain in HDR.
REQ-018 DATA: req_ready[grant] = req_valid[grant] & ~fifo_full.
  - All other req_ready bits are 0 in every state.
REQ-019 Accepted byte: fifo_tx_req=1 and fifo_tx_data=byte exactly one cycle after the req_ready=1 cycle.
  - Outputs are registered.
  - Writes are at most one per cycle.
REQ-020 Accepting a byte with req_last=1 SHALL end the packet.
  - Update last_grant, set grant=3, and return to IDLE.
  - The next grant can occur in the following cycle.
REQ-021 The grant SHALL be held until the packet ends, regardless of other requesters.
  - Packets are never interleaved.
REQ-022 Timeout counter:
  - Increments each DATA cycle where req_valid[grant]=0.
  - Clears on each accepted byte.
  - fifo_full=1 cycles do not increment it.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1:
  - Abort the packet, increment drop_cnt (saturating), update last_grant, and return to IDLE.
  - No terminator byte is written.
REQ-024 fifo_tx_req SHALL never be 1 on two writes for the same accepted byte.
  - A byte with req_valid=1 and req_ready=0 is not consumed.
REQ-025 A single-byte packet (req_last=1 on the first byte) SHALL be legal.
  - It produces the ID byte plus one data byte.
REQ-026 A requester's valid dropping mid-packet without a timeout SHALL only pause the packet; the grant is retained.

Reset
REQ-027 With reset=1 at a clock edge, the following take effect that cycle:
  - State=IDLE, grant=2'd3, last_grant=2.
  - fifo_tx_req=0, fifo_tx_data=8'h00, req_ready=3'b000.
  - Timeout counter=0, drop_cnt=8'h00.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without writing further bytes and without incrementing drop_cnt.
REQ-029 The first grant SHALL be possible in the cycle after reset deasserts.

Verification
REQ-030 Req1 sends 3 bytes 11,22,33 (last on 33), FIFO never full -> FIFO receives A1,11,22,33 on consecutive write strobes; grant returns to 3.
REQ-031 Req0 and req2 both valid in the same cycle after reset -> req0 packet (A0,...) completes fully before req2's A2; the next simultaneous contention grants req1 or req2 before req0.
REQ-032 fifo_full held high for 5 cycles mid-packet -> no fifo_tx_req during the stall, no byte lost or duplicated, timeout counter unchanged.
REQ-033 Req2 sends 1 byte without last, then goes idle; TIMEOUT_CYCLES=16 -> abort 16 cycles later, drop_cnt=1, req0 granted next.
REQ-034 Reset pulsed for 1 cycle during req1's packet -> no further writes, grant=3, drop_cnt=0, and the next grant goes to req0.
REQ-035 INSERT_ID=0, req0 single byte 5A with last -> FIFO receives only 5A; it is written 1 cycle after req_ready.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges three byte streams into one UART TX FIFO, packet-atomic, optional ID prefix byte.
// FIFO write lands one cycle after the accepting handshake; fifo_full stalls all writes and freezes the idle timeout.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
    parameter logic        INSERT_ID      = 1'b1,
    parameter logic [7:0]  ID_BASE        = 8'hA0
) (
    input  logic        clk_50m,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    input  logic        fifo_full,
    output logic        fifo_tx_req,
    output logic [7:0]  fifo_tx_data,
    output logic [1:0]  grant,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] NO_GRANT = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        fifo_tx_req_q, fifo_tx_req_d;
    logic [7:0]  fifo_tx_data_q, fifo_tx_data_d;

    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        accept;

    // First valid requester searching upward from the one after the last owner.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] v);
        logic [3:0] vv;
        logic [1:0] idx;
        logic [1:0] pick;
        vv   = {1'b0, v};
        pick = NO_GRANT;
        idx  = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (pick == NO_GRANT && vv[idx]) begin
                pick = idx;
            end
            idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return pick;
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        case (grant_q)
            2'd0: begin
                sel_valid = req_valid[0];
                sel_last  = req_last[0];
                sel_data  = req_data[7:0];
            end
            2'd1: begin
                sel_valid = req_valid[1];
                sel_last  = req_last[1];
                sel_data  = req_data[15:8];
            end
            2'd2: begin
                sel_valid = req_valid[2];
                sel_last  = req_last[2];
                sel_data  = req_data[23:16];
            end
            default: begin
                sel_valid = 1'b0;
                sel_last  = 1'b0;
                sel_data  = 8'h00;
            end
        endcase
    end

    // A byte offered while reset is high must not be consumed, since no write can follow it.
    assign accept = (state_q == DATA) && sel_valid && !fifo_full && !reset;

    always_comb begin
        req_ready = 3'b000;
        if (accept) begin
            case (grant_q)
                2'd0:    req_ready = 3'b001;
                2'd1:    req_ready = 3'b010;
                2'd2:    req_ready = 3'b100;
                default: req_ready = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        tmo_d          = tmo_q;
        drop_cnt_d     = drop_cnt_q;
        fifo_tx_req_d  = 1'b0;
        fifo_tx_data_d = fifo_tx_data_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(last_grant_q, req_valid);
                    tmo_d   = 16'd0;
                    state_d = INSERT_ID ? HDR : DATA;
                end
            end

            HDR: begin
                if (!fifo_full) begin
                    fifo_tx_req_d  = 1'b1;
                    fifo_tx_data_d = ID_BASE + {6'd0, grant_q};
                    state_d        = DATA;
                end
            end

            DATA: begin
                if (accept) begin
                    fifo_tx_req_d  = 1'b1;
                    fifo_tx_data_d = sel_data;
                    tmo_d          = 16'd0;
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        grant_d      = NO_GRANT;
                        state_d      = IDLE;
                    end
                end else if (!sel_valid && !fifo_full) begin
                    // Only genuine source starvation counts towards the timeout.
                    if (tmo_q >= TIMEOUT_CYCLES - 16'd1) begin
                        last_grant_d = grant_q;
                        grant_d      = NO_GRANT;
                        tmo_d        = 16'd0;
                        state_d      = IDLE;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end

            default: begin
                grant_d = NO_GRANT;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= NO_GRANT;
            last_grant_q   <= 2'd2;
            tmo_q          <= 16'd0;
            drop_cnt_q     <= 8'h00;
            fifo_tx_req_q  <= 1'b0;
            fifo_tx_data_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            tmo_q          <= tmo_d;
            drop_cnt_q     <= drop_cnt_d;
            fifo_tx_req_q  <= fifo_tx_req_d;
            fifo_tx_data_q <= fifo_tx_data_d;
        end
    end

    assign fifo_tx_req  = fifo_tx_req_q;
    assign fifo_tx_data = fifo_tx_data_q;
    assign grant        = grant_q;
    assign drop_cnt     = drop_cnt_q;

endmodule
